// File: rtl/d_mem.sv
// Word-organised data memory for the load/store path: synchronous byte-addressed
// writes, combinational tri-stated reads, asynchronous clear of every word.
module d_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_write,
  output wire  [DATA_WIDTH-1:0] data_read
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BYTE_LIMIT = ADDR_WIDTH'(DEPTH * 4);

  logic [IDX_W-1:0]      word_idx;
  logic                  in_range;
  logic                  wr_en_d;
  logic                  rd_en_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // The full-width compare rejects any address at or beyond the array, so
  // out-of-range accesses can never alias onto a low word.
  assign word_idx = data_addr[IDX_W+1:2];
  assign in_range = (data_addr < BYTE_LIMIT);
  assign wr_en_d  = we & in_range;
  assign rd_en_d  = re & in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_d) begin
      mem_q[word_idx] <= data_write;
    end
  end

  // Single tri-state driver; a same-cycle write becomes visible only after the edge.
  assign data_read = rd_en_d ? mem_q[word_idx] : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_d_mem.sv
// Scoreboard bench for d_mem: stimulus pushes expected read values computed from
// a word-array reference model; a monitor pops and compares at each falling edge.
module tb_d_mem;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic        re;
  logic [31:0] data_addr;
  logic [31:0] data_write;
  wire  [31:0] data_read;

  int errors;
  int checks;

  logic [31:0] exp_q  [$];
  logic [31:0] addr_q [$];
  logic [31:0] ref_mem [1024];
  bit          stim_done;

  d_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(1024)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (we),
    .re         (re),
    .data_addr  (data_addr),
    .data_write (data_write),
    .data_read  (data_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus: inputs change just after a rising edge and are held
  // until the next one; the monitor samples them at the falling edge between.
  task automatic cycle(input bit rst_v, input bit we_v, input bit re_v,
                       input logic [31:0] addr_v, input logic [31:0] wd_v);
    logic [31:0] exp;
    @(posedge clk);
    #1;
    rst_n      = rst_v;
    we         = we_v;
    re         = re_v;
    data_addr  = addr_v;
    data_write = wd_v;
    if (!rst_v) begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    end
    if (re_v && (addr_v < 32'd4096)) exp = ref_mem[addr_v / 4];
    else                             exp = 32'hzzzz_zzzz;
    exp_q.push_back(exp);
    addr_q.push_back(addr_v);
    if (rst_v && we_v && (addr_v < 32'd4096)) ref_mem[addr_v / 4] = wd_v;
  endtask

  initial begin : monitor
    logic [31:0] exp;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        a   = addr_q.pop_front();
        checks++;
        if (data_read !== exp) begin
          errors++;
          $display("FAIL read addr=%h: data_read=%h expected=%h (t=%0t)", a, data_read, exp, $time);
        end
      end
    end
  end

  initial begin : stimulus
    logic [31:0] ra;
    int          sel;
    rst_n = 1'b0; we = 1'b0; re = 1'b0; data_addr = '0; data_write = '0;
    errors = 0; checks = 0; stim_done = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;

    // Reset state and read-enable gating
    cycle(1'b0, 1'b0, 1'b1, 32'd0,    32'h0);
    cycle(1'b0, 1'b0, 1'b1, 32'd4092, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0,    32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0,    32'h0);

    // Basic write / read-back
    cycle(1'b1, 1'b1, 1'b0, 32'd8,  32'hAABB_CCDD);
    cycle(1'b1, 1'b0, 1'b1, 32'd8,  32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'd12, 32'h1234_5678);
    cycle(1'b1, 1'b0, 1'b1, 32'd12, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'd8,  32'h0);

    // Top word, out-of-range read and dropped out-of-range write
    cycle(1'b1, 1'b1, 1'b0, 32'd4092, 32'hFFFF_FFFF);
    cycle(1'b1, 1'b0, 1'b1, 32'd4092, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'd5000, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'd5000, 32'h0BAD_F00D);
    cycle(1'b1, 1'b0, 1'b1, 32'd4092, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'd904,  32'h0);

    // Simultaneous write and read: old value before the edge, new after
    cycle(1'b1, 1'b1, 1'b0, 32'd16, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'd16, 32'h5555_5555);
    cycle(1'b1, 1'b0, 1'b1, 32'd16, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'd18, 32'h0);

    // Asynchronous reset between edges, and a write blocked while held
    cycle(1'b0, 1'b0, 1'b1, 32'd8, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 32'd8, 32'hDEAD_BEEF);
    cycle(1'b1, 1'b0, 1'b1, 32'd8, 32'h0);

    // Randomised traffic, mostly in range with a few far and reset events
    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 80)      ra = $urandom_range(0, 4095);
      else if (sel < 90) ra = $urandom_range(0, 63);
      else               ra = $urandom;
      cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) != 0), ra, $urandom);
    end

    cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'h0);
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: pending=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/d_mem.md
Name: d_mem

Overview:
- Word-organised data memory for the CPU's load/store path: 1024 x 32-bit words, byte-addressed.
- Writes are synchronous on the clock.
- Reads are combinational and tri-stated: the read bus is driven only when a valid read is requested.
- Sits between the execute/memory stage and the register-file write-back mux.

Parameters:
- DATA_WIDTH, 32, width of a memory word and of the data ports.
- ADDR_WIDTH, 32, width of the byte address port.
- DEPTH, 1024, number of words; valid byte addresses are 0 .. DEPTH*4-1 (0..4095).

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- we  input  1  write enable, sampled at the rising edge of clk.
- re  input  1  read enable (combinational).
- data_addr  input  32  byte address; word index = data_addr[11:2].
- data_write  input  32  write data.
- data_read  output  32  read data; high-impedance when not driving.

Behaviour:
- Addressing:
  - Word index is data_addr[11:2].
  - data_addr[1:0] are ignored; unaligned addresses access the containing word.
  - An address is in range iff data_addr < DEPTH*4, i.e. data_addr[31:12] == 0.
- Reset:
  - rst_n low asynchronously clears every word to 32'h0000_0000.
  - While rst_n is low, writes are blocked.
  - data_read follows the read rule below; a read during reset returns 0.
  - Reset asserted mid-operation discards any write at that edge.
- Write:
  - At a rising clk edge with rst_n high, we=1 and the address in range: mem[word index] <= data_write.
  - Out-of-range writes are silently dropped; no aliasing into the array.
  - we=0 leaves memory unchanged.
- Read:
  - data_read = mem[word index] combinationally when re=1 and the address is in range.
  - Otherwise (re=0, or address out of range) data_read = 32'hzzzz_zzzz.
  - No clock latency; the output tracks data_addr and re changes within the same delta.
- Simultaneous we=1 and re=1, same address:
  - Before the clock edge, data_read shows the old contents.
  - After the edge, data_read shows the new contents.
  - No write-through bypass.
- we and re are independent; both may be high in any cycle.
- No error or status outputs. Out-of-range access is signalled only by the high-Z read.
- Read side must be free of latches; the output is a single tri-state driver.

Test Plan:
- Reset, then re=1 at address 0 and address 4092 -> data_read = 00000000 for both; re=0 -> data_read = zzzzzzzz.
- we=1, addr=8, wdata=AABBCCDD for one clock; then we=0, re=1, addr=8 -> AABBCCDD. Write addr=12 with 12345678, read back -> 12345678. Re-read addr=8 -> still AABBCCDD.
- Boundary: write FFFFFFFF to addr 4092, read back -> FFFFFFFF. Read addr=5000 with re=1 -> zzzzzzzz. Write 0BADF00D to addr=5000, then read 4092 and addr 904 (5000 mod 4096) -> unchanged.
- Simultaneous: preload addr 16 with 0, then we=1, re=1, addr=16, wdata=55555555 -> data_read = 00000000 before the edge and 55555555 after it. Unaligned read at addr=18 -> 55555555.
- Async reset mid-run: after the writes above, pulse rst_n low between clock edges -> an immediate read of addr 8 gives 00000000. A write attempted with rst_n low and a clock edge leaves the word at 0.
